// File: rtl/sync_pkg.sv
// Constants and types shared by the beacon transmitter and the slave-side
// sample-and-hold synchroniser, so both ends agree on burst shape.
package sync_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE_HI,
        ST_PULSE_LO,
        ST_GUARD,
        ST_DONE
    } state_t;

    localparam int NUM_PULSES   = 8;
    localparam int MAX_PERIOD   = 19999;
    localparam int RX_TIMEOUT   = 20000;
    localparam int GUARD_CYCLES = 16;

    // A burst is legal when both the high and the low phase last at least two
    // cycles (the receiver's 2-flop synchroniser needs that) and the period
    // stays below the receiver timeout.
    function automatic logic cfg_legal(input int unsigned period,
                                       input int unsigned width,
                                       input int unsigned max_period);
        return (width >= 2) && (period >= width + 2) && (period <= max_period);
    endfunction

endpackage

// File: rtl/sync_period_timer.sv
// Phase counter for one beacon period: cleared by load, free-running
// otherwise, with a terminal-count flag against a caller-supplied value.
module sync_period_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // Count cycles since the last load; the owner bounds the count so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/sync_beacon_tx.sv
// Master-side RF sync beacon generator: emits a burst of fixed-width pulses
// at a programmed period, waits a guard interval, then strobes done.
module sync_beacon_tx
    import sync_pkg::*;
#(
    parameter int NUM_PULSES   = sync_pkg::NUM_PULSES,
    parameter int CNT_W        = 16,
    parameter int MAX_PERIOD   = sync_pkg::MAX_PERIOD,
    parameter int GUARD_CYCLES = sync_pkg::GUARD_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] period_cfg,
    input  logic [7:0]       width_cfg,
    output logic             rf_out,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [3:0]       pulse_idx
);

    state_t           state;
    logic [CNT_W-1:0] period_q;
    logic [7:0]       width_q;
    logic [CNT_W-1:0] tc_val;
    logic             tmr_load;
    logic             tmr_tc;
    logic             start_ok;
    logic             more_pulses;

    assign start_ok    = cfg_legal(32'(period_cfg), 32'(width_cfg), MAX_PERIOD);
    assign more_pulses = (32'(pulse_idx) < NUM_PULSES);

    // The phase counter restarts at every rising edge of rf_out and at GUARD
    // entry; it is held clear while idle so the first pulse starts from zero.
    assign tmr_load = (state == ST_IDLE) || (state == ST_DONE) ||
                      ((state == ST_PULSE_LO) && tmr_tc);

    // Select the last counter value of the current phase from the latched config.
    always_comb begin
        tc_val = '0;
        case (state)
            ST_PULSE_HI: tc_val = CNT_W'(width_q) - CNT_W'(1);
            ST_PULSE_LO: tc_val = period_q - CNT_W'(1);
            ST_GUARD:    tc_val = CNT_W'(GUARD_CYCLES - 1);
            default:     tc_val = '0;
        endcase
    end

    sync_period_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .tc_val (tc_val),
        .tc     (tmr_tc)
    );

    // Burst sequencer; every output is registered so rf_out is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            period_q  <= '0;
            width_q   <= '0;
            rf_out    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            pulse_idx <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            if (abort && (state != ST_IDLE)) begin
                state  <= ST_IDLE;
                rf_out <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            if (start_ok) begin
                                period_q  <= period_cfg;
                                width_q   <= width_cfg;
                                // Cleared and then counted for the first pulse.
                                pulse_idx <= 4'd1;
                                rf_out    <= 1'b1;
                                busy      <= 1'b1;
                                state     <= ST_PULSE_HI;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    ST_PULSE_HI: begin
                        if (tmr_tc) begin
                            rf_out <= 1'b0;
                            state  <= ST_PULSE_LO;
                        end
                    end
                    ST_PULSE_LO: begin
                        if (tmr_tc) begin
                            if (more_pulses) begin
                                rf_out    <= 1'b1;
                                pulse_idx <= pulse_idx + 4'd1;
                                state     <= ST_PULSE_HI;
                            end else begin
                                state <= ST_GUARD;
                            end
                        end
                    end
                    ST_GUARD: begin
                        if (tmr_tc) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        rf_out <= 1'b0;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sync_beacon_tx.sv
// Directed self-checking bench for sync_beacon_tx. Cycle 1 is the cycle
// after the edge that samples start; outputs are sampled 1 time unit after
// each rising edge.
module tb_sync_beacon_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] period_cfg;
    logic [7:0]  width_cfg;
    logic        rf_out;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [3:0]  pulse_idx;

    int n_checks = 0;
    int n_fail   = 0;

    // Burst observations filled in by run_monitor.
    int rise_cyc [16];
    int hi_len   [16];
    int n_rises;
    int done_cyc;
    int done_cnt;
    int idx_at_done;
    int busy_low_cyc;

    sync_beacon_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .period_cfg (period_cfg),
        .width_cfg  (width_cfg),
        .rf_out     (rf_out),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .pulse_idx  (pulse_idx)
    );

    // 10 time-unit clock period.
    always #5 clk = ~clk;

    // Advance to the sample point of the next cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present start for one edge; returns at the sample point of cycle 1.
    task automatic issue_start(input int p, input int w);
        period_cfg = 16'(p);
        width_cfg  = 8'(w);
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    // Record rising edges, high times and done/busy timing from cycle 1
    // until busy drops or the cycle budget runs out.
    task automatic run_monitor(input int max_cycles);
        logic prev;
        prev         = 1'b0;
        n_rises      = 0;
        done_cyc     = -1;
        done_cnt     = 0;
        idx_at_done  = -1;
        busy_low_cyc = -1;
        for (int k = 0; k < 16; k++) begin
            rise_cyc[k] = -1;
            hi_len[k]   = 0;
        end
        for (int n = 1; n <= max_cycles; n++) begin
            if (n > 1) step();
            if (rf_out === 1'b1 && prev !== 1'b1) begin
                if (n_rises < 16) rise_cyc[n_rises] = n;
                n_rises++;
            end
            if (rf_out === 1'b1 && n_rises > 0 && n_rises <= 16) hi_len[n_rises-1]++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc    = n;
                    idx_at_done = int'(pulse_idx);
                end
            end
            if (busy !== 1'b1) begin
                busy_low_cyc = n;
                break;
            end
            prev = rf_out;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        period_cfg = '0;
        width_cfg  = '0;
        #23;
        n_checks++; if (rf_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rf_out: got %b expected 0", rf_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cfg_err: got %b expected 0", cfg_err); end
        n_checks++; if (pulse_idx !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_pulse_idx: got %0d expected 0", pulse_idx); end
        rst_n = 1'b1;
        step();
        step();
    endtask

    // Checks a complete burst against period p, width w.
    task automatic check_burst(input string tag, input int p, input int w);
        n_checks++; if (n_rises != 8) begin n_fail++; $display("[TB] FAIL %s_rises: got %0d expected 8", tag, n_rises); end
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (rise_cyc[k] != 1 + k * p) begin n_fail++; $display("[TB] FAIL %s_rise%0d: got cycle %0d expected %0d", tag, k, rise_cyc[k], 1 + k * p); end
            n_checks++; if (hi_len[k] != w) begin n_fail++; $display("[TB] FAIL %s_high%0d: got %0d expected %0d", tag, k, hi_len[k], w); end
        end
        n_checks++; if (done_cyc != 1 + 8 * p + 16) begin n_fail++; $display("[TB] FAIL %s_done_cycle: got %0d expected %0d", tag, done_cyc, 1 + 8 * p + 16); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("[TB] FAIL %s_done_count: got %0d expected 1", tag, done_cnt); end
        n_checks++; if (idx_at_done != 8) begin n_fail++; $display("[TB] FAIL %s_idx_at_done: got %0d expected 8", tag, idx_at_done); end
        n_checks++; if (busy_low_cyc != 2 + 8 * p + 16) begin n_fail++; $display("[TB] FAIL %s_busy_low: got %0d expected %0d", tag, busy_low_cyc, 2 + 8 * p + 16); end
    endtask

    task automatic test_nominal();
        $display("[TB] nominal burst P=5000 W=4");
        issue_start(5000, 4);
        run_monitor(45000);
        check_burst("nominal", 5000, 4);
    endtask

    // Starts in the very cycle busy has just dropped, at the minimum legal config.
    task automatic test_back_to_back();
        $display("[TB] back-to-back minimum config P=4 W=2");
        issue_start(4, 2);
        run_monitor(200);
        check_burst("min_cfg", 4, 2);
    endtask

    task automatic test_illegal();
        int p_tab [4] = '{20000, 10, 5, 19999};
        int w_tab [4] = '{4,     1,  4, 4};
        $display("[TB] config legality");
        for (int i = 0; i < 3; i++) begin
            step();
            issue_start(p_tab[i], w_tab[i]);
            n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("[TB] FAIL illegal%0d_cfg_err: got %b expected 1", i, cfg_err); end
            n_checks++; if (busy !== 1'b0 || rf_out !== 1'b0) begin n_fail++; $display("[TB] FAIL illegal%0d_idle: got busy=%b rf_out=%b expected 0 0", i, busy, rf_out); end
            step();
            n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL illegal%0d_strobe: got %b expected 0", i, cfg_err); end
        end
        step();
        issue_start(p_tab[3], w_tab[3]);
        n_checks++; if (busy !== 1'b1 || cfg_err !== 1'b0 || rf_out !== 1'b1) begin n_fail++; $display("[TB] FAIL max_period_accept: got busy=%b cfg_err=%b rf_out=%b expected 1 0 1", busy, cfg_err, rf_out); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    // A second start plus a period change in mid-burst must not disturb the burst.
    task automatic test_busy_start();
        $display("[TB] start while busy P=100 W=3");
        issue_start(100, 3);
        fork
            run_monitor(1000);
            begin
                repeat (249) step();
                start      = 1'b1;
                period_cfg = 16'd50;
                step();
                start      = 1'b0;
            end
        join
        check_burst("busy_start", 100, 3);
        period_cfg = 16'd100;
    endtask

    task automatic test_abort();
        int done_seen;
        $display("[TB] abort mid-pulse P=1000 W=4");
        step();
        issue_start(1000, 4);
        repeat (3001) step();
        n_checks++; if (rf_out !== 1'b1 || pulse_idx !== 4'd4) begin n_fail++; $display("[TB] FAIL pre_abort: got rf_out=%b idx=%0d expected 1 4", rf_out, pulse_idx); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++; if (rf_out !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_outputs: got rf_out=%b busy=%b expected 0 0", rf_out, busy); end
        n_checks++; if (pulse_idx !== 4'd4) begin n_fail++; $display("[TB] FAIL abort_pulse_idx: got %0d expected 4", pulse_idx); end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1 || rf_out === 1'b1) done_seen++;
            step();
        end
        n_checks++; if (done_seen != 0) begin n_fail++; $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", done_seen); end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || rf_out !== 1'b0 || cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL start_abort_idle: got busy=%b rf_out=%b cfg_err=%b expected 0 0 0", busy, rf_out, cfg_err); end
        n_checks++; if (pulse_idx !== 4'd4) begin n_fail++; $display("[TB] FAIL start_abort_idx: got %0d expected 4", pulse_idx); end
        step();
    endtask

    task automatic test_async_reset();
        $display("[TB] async reset mid-pulse P=100 W=10");
        issue_start(100, 10);
        step();
        step();
        n_checks++; if (rf_out !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_rf_out: got %b expected 1", rf_out); end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (rf_out !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_outputs: got rf_out=%b busy=%b expected 0 0", rf_out, busy); end
        n_checks++; if (pulse_idx !== 4'd0 || done !== 1'b0 || cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_state: got idx=%0d done=%b cfg_err=%b expected 0 0 0", pulse_idx, done, cfg_err); end
        #1;
        rst_n = 1'b1;
        step();
        issue_start(100, 10);
        run_monitor(1000);
        check_burst("post_reset", 100, 10);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_illegal();
        test_busy_start();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
